// File: rtl/cache_tag_ctrl_if.sv
// Request/response and next-level memory handshake bundle for cache_tag_ctrl.
// The master side is the trace source together with the next-level memory model.
interface cache_tag_ctrl_if #(
  parameter int unsigned ADDRESS_BITS = 32
) ();
  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_op;
  logic [ADDRESS_BITS-1:0] req_addr;
  logic                    resp_valid;
  logic                    resp_hit;
  logic                    mem_req_valid;
  logic                    mem_req_write;
  logic [ADDRESS_BITS-1:0] mem_req_addr;
  logic                    mem_ack;

  modport master (
    output req_valid, req_op, req_addr, mem_ack,
    input  req_ready, resp_valid, resp_hit, mem_req_valid, mem_req_write, mem_req_addr
  );

  modport slave (
    input  req_valid, req_op, req_addr, mem_ack,
    output req_ready, resp_valid, resp_hit, mem_req_valid, mem_req_write, mem_req_addr
  );
endinterface

// File: rtl/cache_tag_ctrl.sv
// Sequencing controller for a 2-way set-associative cache tag store:
// lookup, LRU replacement, dirty write-back, line fill and statistics.
module cache_tag_ctrl #(
  parameter int unsigned ADDRESS_BITS = 32,
  parameter int unsigned OFFSET_BITS  = 6,
  parameter int unsigned INDEX_BITS   = 4,
  parameter int unsigned CNT_BITS     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_tag_ctrl_if.slave     bus,
  output logic [CNT_BITS-1:0] hit_count,
  output logic [CNT_BITS-1:0] miss_count,
  output logic [CNT_BITS-1:0] wb_count
);

  localparam int unsigned TAG_BITS = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned SETS     = 2 ** INDEX_BITS;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INVAL = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_RESP
  } state_t;

  state_t                  r_state;
  logic [1:0]              r_op;
  logic [TAG_BITS-1:0]     r_req_tag;
  logic [INDEX_BITS-1:0]   r_idx;
  logic                    r_victim;
  logic [SETS-1:0][1:0]    r_valid;
  logic [SETS-1:0][1:0]    r_dirty;
  logic [SETS-1:0]         r_lru;
  logic [TAG_BITS-1:0]     r_tag [SETS][2];

  logic                    r_req_ready;
  logic                    r_resp_valid;
  logic                    r_resp_hit;
  logic                    r_mem_valid;
  logic                    r_mem_write;
  logic [ADDRESS_BITS-1:0] r_mem_addr;
  logic [CNT_BITS-1:0]     r_hit_count;
  logic [CNT_BITS-1:0]     r_miss_count;
  logic [CNT_BITS-1:0]     r_wb_count;

  logic [1:0]              w_set_valid;
  logic [1:0]              w_set_dirty;
  logic                    w_hit0;
  logic                    w_hit1;
  logic                    w_hit_way;
  logic                    w_victim;
  logic                    w_tag_we;
  logic [ADDRESS_BITS-1:0] w_fill_addr;
  logic [ADDRESS_BITS-1:0] w_wb_addr;
  logic                    w_unused_offset;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  // Lookup and replacement choice for the registered set; way 0 wins a double match.
  assign w_set_valid = r_valid[r_idx];
  assign w_set_dirty = r_dirty[r_idx];
  assign w_hit0      = w_set_valid[0] && (r_tag[r_idx][0] == r_req_tag);
  assign w_hit1      = w_set_valid[1] && (r_tag[r_idx][1] == r_req_tag);
  assign w_hit_way   = !w_hit0;
  assign w_victim    = !w_set_valid[0] ? 1'b0 :
                       !w_set_valid[1] ? 1'b1 : r_lru[r_idx];
  assign w_fill_addr = {r_req_tag, r_idx, OFFSET_BITS'(0)};
  assign w_wb_addr   = {r_tag[r_idx][w_victim], r_idx, OFFSET_BITS'(0)};
  assign w_tag_we    = (r_state == S_FILL) && bus.mem_ack;

  assign w_unused_offset = ^bus.req_addr[OFFSET_BITS-1:0];

  // Tag array carries no reset; valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (w_tag_we) begin
      r_tag[r_idx][r_victim] <= r_req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= 2'b00;
      r_req_tag    <= '0;
      r_idx        <= '0;
      r_victim     <= 1'b0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_lru        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_wb_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op        <= bus.req_op;
            r_req_tag   <= bus.req_addr[ADDRESS_BITS-1 -: TAG_BITS];
            r_idx       <= bus.req_addr[OFFSET_BITS +: INDEX_BITS];
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (r_op == OP_INVAL) begin
            r_valid      <= '0;
            r_dirty      <= '0;
            r_lru        <= '0;
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b0;
            r_state      <= S_RESP;
          end else if (r_op == OP_NOP) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b0;
            r_state      <= S_RESP;
          end else if (w_hit0 || w_hit1) begin
            r_lru[r_idx] <= ~w_hit_way;
            if (r_op == OP_WRITE) begin
              r_dirty[r_idx][w_hit_way] <= 1'b1;
            end
            r_hit_count  <= sat_inc(r_hit_count);
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_miss_count <= sat_inc(r_miss_count);
            r_victim     <= w_victim;
            r_mem_valid  <= 1'b1;
            if (w_set_valid[w_victim] && w_set_dirty[w_victim]) begin
              r_mem_write <= 1'b1;
              r_mem_addr  <= w_wb_addr;
              r_state     <= S_WB;
            end else begin
              r_mem_write <= 1'b0;
              r_mem_addr  <= w_fill_addr;
              r_state     <= S_FILL;
            end
          end
        end

        S_WB: begin
          if (bus.mem_ack) begin
            r_wb_count  <= sat_inc(r_wb_count);
            r_mem_write <= 1'b0;
            r_mem_addr  <= w_fill_addr;
            r_state     <= S_FILL;
          end
        end

        S_FILL: begin
          if (bus.mem_ack) begin
            r_valid[r_idx][r_victim] <= 1'b1;
            r_dirty[r_idx][r_victim] <= (r_op == OP_WRITE);
            r_lru[r_idx]             <= ~r_victim;
            r_mem_valid              <= 1'b0;
            r_mem_addr               <= '0;
            r_resp_valid             <= 1'b1;
            r_resp_hit               <= 1'b0;
            r_state                  <= S_RESP;
          end
        end

        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_hit   <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_hit      = r_resp_hit;
  assign bus.mem_req_valid = r_mem_valid;
  assign bus.mem_req_write = r_mem_write;
  assign bus.mem_req_addr  = r_mem_addr;
  assign hit_count         = r_hit_count;
  assign miss_count        = r_miss_count;
  assign wb_count          = r_wb_count;

endmodule
